// File: rtl/dcache_mem_port.sv
// rtl/dcache_mem_port.sv - load/store-buffer responder serialising one access over a byte-wide memory bus
// Uncached, one access in flight, little-endian; loads zero-extend, IO writes stall on ioBufferFull.
module dcache_mem_port #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic [1:0]            accessType,
  input  logic                  readWriteOut,
  input  logic [31:0]           dataAddr,
  input  logic [31:0]           dataOut,
  output logic                  dataValid,
  output logic [31:0]           dataIn,
  output logic                  dataWriteSuc,
  input  logic [7:0]            memDataIn,
  output logic [7:0]            memDataOut,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memWrite,
  input  logic                  ioBufferFull
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  last_q, last_d;
  logic        valid_q, valid_d;
  logic        suc_q, suc_d;

  logic [ADDR_WIDTH-1:0] byte_addr;
  logic                  io_stall;
  logic [1:0]            cap_idx;

  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      suc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      suc_q   <= suc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    idx_d      = idx_q;
    last_d     = last_q;
    valid_d    = 1'b0;
    suc_d      = 1'b0;
    memWrite   = 1'b0;
    memAddr    = '0;
    memDataOut = '0;
    byte_addr  = addr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(idx_q);
    io_stall   = (addr_q[17:16] == 2'b11) && ioBufferFull;
    cap_idx    = idx_q - 2'd1;

    case (state_q)
      S_IDLE: begin
        if (accessType != 2'b00) begin
          addr_d = dataAddr;
          idx_d  = 2'd0;
          last_d = (accessType == 2'b01) ? 2'd0 :
                   (accessType == 2'b10) ? 2'd1 : 2'd3;
          if (readWriteOut) begin
            state_d = S_READ;
            rdata_d = '0;
          end else begin
            state_d = S_WRITE;
            wdata_d = dataOut;
          end
        end
      end
      S_READ: begin
        memAddr = byte_addr;
        // Memory answers one cycle late, so this cycle carries the previous address's byte.
        if (idx_q != 2'd0) begin
          rdata_d[{cap_idx, 3'b000} +: 8] = memDataIn;
        end
        if (idx_q == last_q) begin
          state_d = S_WAIT;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_WAIT: begin
        rdata_d[{idx_q, 3'b000} +: 8] = memDataIn;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      S_WRITE: begin
        memAddr    = byte_addr;
        memDataOut = wdata_q[{idx_q, 3'b000} +: 8];
        if (!io_stall) begin
          memWrite = 1'b1;
          if (idx_q == last_q) begin
            suc_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dataValid    = valid_q;
  assign dataWriteSuc = suc_q;
  assign dataIn       = rdata_q;

endmodule
